// File: rtl/logic_unit_controller_if.sv
// logic_unit_controller_if
// Command and result handshake bundle for the 8-bit logic datapath sequencer.
//   cmd_valid / cmd_ready    : command handshake (source -> controller)
//   cmd_op [2:0]             : operation code
//   cmd_operand [WIDTH-1:0]  : operand B
//   res_valid / res_ready    : result handshake (controller -> consumer)
//   res_data [WIDTH-1:0]     : accumulator value after the command
//   res_zero                 : res_data == 0
// Modports: master = command source / result consumer, slave = controller.
interface logic_unit_controller_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_operand;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_operand, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, res_ready,
    output cmd_ready, res_valid, res_data, res_zero
  );
endinterface

// File: rtl/logic_unit_controller.sv
// logic_unit_controller
// Sequencer for the bitwise logic datapath. Commands are buffered in a small
// FIFO, executed one at a time against a persistent accumulator, and every
// result is returned through a valid/ready response port.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : logic_unit_controller_if.slave (command and result handshakes)
//   busy  : FSM not idle or FIFO not empty
module logic_unit_controller #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  logic_unit_controller_if.slave   bus,
  output logic                     busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_AND   = 3'b001,
    OP_OR    = 3'b010,
    OP_NOT   = 3'b011,
    OP_XOR   = 3'b100,
    OP_NAND  = 3'b101,
    OP_NOR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
  } cmd_t;

  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_t           state_q;
  state_t           state_d;
  cmd_t             cmd_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] alu_result;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;

  assign full          = (count == CNT_W'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign push          = bus.cmd_valid && !full;
  assign bus.cmd_ready = !full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = (res_data_q == '0);
  assign busy          = (state_q != IDLE) || !empty;

  // Storage needs no reset: pointers and count alone define the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{op: bus.cmd_op, operand: bus.cmd_operand};
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The gate-level units this block drives, expressed as one mux per opcode.
  always_comb begin
    alu_result = '0;
    case (op_t'(cmd_reg.op))
      OP_LOAD:  alu_result = cmd_reg.operand;
      OP_AND:   alu_result = acc & cmd_reg.operand;
      OP_OR:    alu_result = acc | cmd_reg.operand;
      OP_NOT:   alu_result = ~acc;
      OP_XOR:   alu_result = acc ^ cmd_reg.operand;
      OP_NAND:  alu_result = ~(acc & cmd_reg.operand);
      OP_NOR:   alu_result = ~(acc | cmd_reg.operand);
      OP_CLEAR: alu_result = '0;
      default:  alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The pop decision uses the registered count, so a command pushed on this
  // edge is only seen by IDLE on the following edge.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // res_data is only written in EXEC, so it stays frozen for all of RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_reg     <= '0;
      acc         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      if (pop) begin
        cmd_reg <= fifo_mem[rd_ptr];
      end
      if (state_q == EXEC) begin
        acc         <= alu_result;
        res_data_q  <= alu_result;
        res_valid_q <= 1'b1;
      end else if (state_q == RESP && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_controller.sv
// tb_logic_unit_controller
// Self-checking bench for logic_unit_controller: a table of directed command
// vectors, hand-written latency/backpressure/reset sequences, and randomized
// traffic scored against a command-stream reference model.
module tb_logic_unit_controller;

  localparam int WIDTH      = 8;
  localparam int FIFO_DEPTH = 4;

  localparam logic [2:0] LOAD  = 3'd0;
  localparam logic [2:0] AND_  = 3'd1;
  localparam logic [2:0] OR_   = 3'd2;
  localparam logic [2:0] NOT_  = 3'd3;
  localparam logic [2:0] XOR_  = 3'd4;
  localparam logic [2:0] NAND_ = 3'd5;
  localparam logic [2:0] NOR_  = 3'd6;
  localparam logic [2:0] CLR   = 3'd7;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  logic_unit_controller_if #(.WIDTH(WIDTH)) bus ();

  logic_unit_controller #(
    .WIDTH(WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] operand;
    logic [7:0] exp_data;
    logic       exp_zero;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       zero;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  logic [7:0] model_acc;
  bit         rand_done;
  vec_t       vecs [15];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Reference: the new accumulator is simply the spec's table of eight
  // possible outcomes, selected by the opcode.
  function automatic logic [7:0] ref_result(input logic [7:0] acc,
                                            input logic [2:0] op,
                                            input logic [7:0] b);
    logic [7:0] outcomes [8];
    outcomes = '{b, acc & b, acc | b, ~acc, acc ^ b, ~(acc & b), ~(acc | b), 8'h00};
    return outcomes[op];
  endfunction

  // Result monitor: sampled on the falling edge, where a pending handshake
  // is already decided for the next rising edge.
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs) begin
        checkOutput("res_valid_hold", 32'(bus.res_valid), 32'd1);
        checkOutput("res_data_hold", 32'(bus.res_data), 32'(prev_data));
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: actual=0x%0h required=none", bus.res_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("res_data", 32'(bus.res_data), 32'(e.data));
          checkOutput("res_zero", 32'(bus.res_zero), 32'(e.zero));
        end
      end
      prev_valid = bus.res_valid;
      prev_data  = bus.res_data;
      prev_hs    = bus.res_valid && bus.res_ready;
    end
  end

  // Called at posedge+1; holds the command until a handshake edge or timeout.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] b,
                               input logic [7:0] exp_data, input logic exp_zero,
                               input int max_wait, output bit accepted);
    exp_t e;
    accepted        = 1'b0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_operand = b;
    for (int i = 0; i < max_wait; i++) begin
      if (bus.cmd_ready) begin
        e.data = exp_data;
        e.zero = exp_zero;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_model(input logic [2:0] op, input logic [7:0] b,
                            input int max_wait, output bit accepted);
    logic [7:0] r;
    r = ref_result(model_acc, op, b);
    applyStimulus(op, b, r, (r == 8'h00), max_wait, accepted);
    if (accepted) model_acc = r;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(posedge clk);
      #1;
    end
    checkOutput({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    checkOutput({name, "_idle"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_random(input string name, input int n, input bit toggle_ready);
    bit acc_ok;
    rand_done     = 1'b0;
    bus.res_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          if (toggle_ready) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
          end
          send_model(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 100, acc_ok);
          checkOutput({name, "_accept"}, 32'(acc_ok), 32'd1);
        end
        wait_drain(name, 400);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          if (toggle_ready && !rand_done) bus.res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.res_ready = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin : main
    bit         ok;
    int         accepted_cnt;

    vecs[0]  = '{LOAD,  8'hFF, 8'hFF, 1'b0};
    vecs[1]  = '{NOT_,  8'h00, 8'h00, 1'b1};
    vecs[2]  = '{LOAD,  8'h00, 8'h00, 1'b1};
    vecs[3]  = '{NOT_,  8'h12, 8'hFF, 1'b0};
    vecs[4]  = '{LOAD,  8'h99, 8'h99, 1'b0};
    vecs[5]  = '{NOT_,  8'h00, 8'h66, 1'b0};
    vecs[6]  = '{LOAD,  8'hF0, 8'hF0, 1'b0};
    vecs[7]  = '{NOT_,  8'hAB, 8'h0F, 1'b0};
    vecs[8]  = '{LOAD,  8'hF0, 8'hF0, 1'b0};
    vecs[9]  = '{AND_,  8'h3C, 8'h30, 1'b0};
    vecs[10] = '{OR_,   8'h0F, 8'h3F, 1'b0};
    vecs[11] = '{XOR_,  8'hFF, 8'hC0, 1'b0};
    vecs[12] = '{NAND_, 8'h0F, 8'hFF, 1'b0};
    vecs[13] = '{NOR_,  8'h00, 8'h00, 1'b1};
    vecs[14] = '{CLR,   8'h5A, 8'h00, 1'b1};

    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 3'd0;
    bus.cmd_operand = 8'h00;
    bus.res_ready   = 1'b0;
    model_acc       = 8'h00;
    rand_done       = 1'b0;

    // Reset values, plus a push attempted while reset is held.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(bus.res_data), 32'd0);
    checkOutput("rst_res_zero", 32'(bus.res_zero), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = LOAD;
    bus.cmd_operand = 8'h77;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    reset         = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_push_discarded", 32'(busy), 32'd0);
    bus.res_ready = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].op, vecs[i].operand, vecs[i].exp_data, vecs[i].exp_zero, 20, ok);
      checkOutput($sformatf("vec%0d_accept", i), 32'(ok), 32'd1);
      if (ok) model_acc = vecs[i].exp_data;
    end
    wait_drain("table", 200);

    // Latency from an idle controller: valid exactly two edges after handshake.
    send_model(LOAD, 8'h5A, 5, ok);
    checkOutput("lat_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("lat_k1_valid", 32'(bus.res_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_k2_valid", 32'(bus.res_valid), 32'd1);
    send_model(NOT_, 8'h00, 20, ok);
    wait_drain("latency", 100);

    // Backpressure: FIFO_DEPTH queued plus one in flight.
    bus.res_ready = 1'b0;
    accepted_cnt  = 0;
    for (int v = 1; v <= 6; v++) begin
      send_model(LOAD, 8'(v), 8, ok);
      if (ok) accepted_cnt++;
    end
    checkOutput("bp_accepted", 32'(accepted_cnt), 32'(FIFO_DEPTH + 1));
    checkOutput("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("bp_res_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("bp_res_data", 32'(bus.res_data), 32'h01);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_ready_still_low", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("bp_ready_back", 32'(bus.cmd_ready), 32'd1);
    wait_drain("backpressure", 200);

    // Sustained traffic with the consumer always ready, then random stalls.
    run_random("sustained", 20, 1'b0);
    run_random("random", 40, 1'b1);

    // Reset while a command executes, with two more still queued.
    bus.res_ready = 1'b1;
    send_model(LOAD, 8'hAA, 20, ok);
    send_model(AND_, 8'h0F, 20, ok);
    send_model(OR_, 8'h30, 20, ok);
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) break;
      @(posedge clk);
      #1;
    end
    checkOutput("midrst_first_valid", 32'(bus.res_valid), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_res_data", 32'(bus.res_data), 32'd0);
    checkOutput("midrst_res_zero", 32'(bus.res_zero), 32'd1);
    exp_q.delete();
    model_acc = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midrst_no_stale_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("midrst_no_stale_busy", 32'(busy), 32'd0);
    send_model(NOT_, 8'h00, 20, ok);
    checkOutput("midrst_not_accept", 32'(ok), 32'd1);
    wait_drain("midrst", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_controller.md
Name: logic_unit_controller

Overview:
Sequencer for the team's 8-bit bitwise logic datapath (NOT/AND/OR and derivatives). It accepts operation commands through a valid/ready port and buffers them in a small FIFO. Each command executes against an internal accumulator. Every command's result is returned through a valid/ready response port. It sits between a command source (testbench or future CPU decode stage) and the structural 8-bit gate units, which it drives.

Parameters:
WIDTH, 8, datapath/accumulator width in bits
FIFO_DEPTH, 4, command FIFO entries (power of two, >= 2)

Ports:
clk  input  1  single system clock, rising-edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept command (= not full)
cmd_op  input  3  operation code
cmd_operand  input  WIDTH  operand B
res_valid  output  1  result present
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  accumulator value after the command
res_zero  output  1  res_data == 0
busy  output  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset is async, active-high, and has priority over everything. While it is asserted: acc=0, FIFO empty (count=0, pointers=0), state=IDLE, res_valid=0, res_data=0, res_zero=1, busy=0.
- cmd_ready = !full. It reads 1 during reset, but pushes during reset are discarded.
- Opcodes (acc' = new accumulator):
  - 000 LOAD: acc' = B
  - 001 AND: acc' = acc & B
  - 010 OR: acc' = acc | B
  - 011 NOT: acc' = ~acc (B ignored)
  - 100 XOR: acc' = acc ^ B
  - 101 NAND: acc' = ~(acc & B)
  - 110 NOR: acc' = ~(acc | B)
  - 111 CLEAR: acc' = 0
- All results are WIDTH bits. No carry, no flags other than res_zero.
- Push occurs on a rising edge with cmd_valid & cmd_ready. Entries stay in order. A push into a full FIFO cannot occur.
- FSM states:
  - IDLE: if FIFO not empty, pop the head into cmd_reg and go to EXEC. Otherwise stay.
  - EXEC: acc <= f(acc, cmd_reg), res_data <= f(acc, cmd_reg), res_valid <= 1, go to RESP.
  - RESP: hold res_valid and res_data stable until res_ready=1. On that edge res_valid <= 0 and go to IDLE.
- Latency: a command accepted at edge k is popped at edge k+1 (if the FIFO was otherwise empty and FSM IDLE). res_valid is high from edge k+2.
- Throughput: 1 result per 3 cycles with res_ready tied high.
- Simultaneous push and pop on one edge: count unchanged, both pointers advance and wrap modulo FIFO_DEPTH.
- A push to an empty FIFO is not visible to IDLE until the next edge (no bypass).
- Backpressure: while in RESP with res_ready=0, no pop occurs. The FIFO fills, after which cmd_ready=0. Total commands accepted = FIFO_DEPTH + 1 (one in flight).
- res_valid must never drop without a res_ready handshake, and res_data must not change while res_valid=1.
- acc persists between commands. Only LOAD, CLEAR or reset re-initialise it.
- Reset mid-operation: the in-flight command and all queued commands are discarded, and no result is produced for them.
- res_zero is combinational from res_data.

Test Plan:
- LOAD 0xFF, NOT, res_ready=1 -> results 0xFF then 0x00 (res_zero=1). Push LOAD 0x00, NOT -> results 0x00, 0xFF.
- LOAD 0x99, NOT -> 0x66. LOAD 0xF0, NOT -> 0x0F. Check res_valid rises exactly 2 edges after the first command handshake.
- Chain LOAD 0xF0, AND 0x3C, OR 0x0F, XOR 0xFF, NAND 0x0F, NOR 0x00, CLEAR -> results 0xF0, 0x30, 0x3F, 0xC0, 0xFF, 0x00, 0x00, in order.
- res_ready=0, cmd_valid held with 6 LOADs (0x01..0x06) -> exactly 5 accepted, cmd_ready=0, res_data=0x01 stable. Release res_ready -> results 0x01..0x05 in order, cmd_ready returns to 1 after the first pop.
- Sustained push/pop with res_ready=1 for 20 commands -> pointer wrap exercised, no loss or duplication, results match the model.
- Queue 3 commands, assert reset while in EXEC -> res_valid=0, busy=0, acc=0 immediately. After release, no stale results appear. NOT -> 0xFF.
